// File: rtl/des_key_schedule.sv
// des_key_schedule
// Sequential DES subkey generator feeding the F-function key input.
// A key is captured in IDLE on `start`. PC-1 is applied to it, and the
// 16 round subkeys are then presented one per valid/ready handshake:
// K1..K16 for encrypt, or K16..K1 for decrypt.
// Bit 1 is the MSB of every vector (DES numbering).
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   key_in[1:64]  DES key including parity bits, sampled on accept
//   decrypt       0 = K1..K16, 1 = K16..K1, sampled on accept
//   start         request a schedule (accepted only in IDLE)
//   busy          high while subkeys are being presented
//   subkey[1:48]  PC-2 of the current C/D halves
//   subkey_valid  subkey / round_idx are valid
//   subkey_ready  consumer accepts on subkey_valid && subkey_ready
//   round_idx     DES round number of the presented subkey
//   done          one-cycle pulse after the 16th subkey is accepted
//   parity_err    some key byte had even parity (registered at accept)
module des_key_schedule #(
  parameter bit PARITY_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        start,
  output logic        busy,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [4:0]  round_idx,
  output logic        done,
  output logic        parity_err
);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [1:28] c_reg, d_reg;
  logic [4:0]  cnt_reg;
  logic        dec_reg;
  logic        perr_reg;

  logic [1:56] pc1_out;
  logic [1:56] cd;
  logic [1:8]  byte_odd;
  logic        parity_bad;
  logic        accept;
  logic        advance;

  // Left-shift count of DES round r (1..16).
  function automatic logic [1:0] shift_amt(input logic [4:0] r);
    shift_amt = (r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] v, input logic [1:0] n);
    case (n)
      2'd1:    rotl = {v[2:28], v[1]};
      2'd2:    rotl = {v[3:28], v[1:2]};
      default: rotl = v;
    endcase
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] v, input logic [1:0] n);
    case (n)
      2'd1:    rotr = {v[28], v[1:27]};
      2'd2:    rotr = {v[27:28], v[1:26]};
      default: rotr = v;
    endcase
  endfunction

  // Permuted choices are pure wiring.
  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_out[gi+1] = key_in[PC1[gi]];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign subkey[gi+1] = cd[PC2[gi]];
    end
    for (gi = 0; gi < 8; gi++) begin : g_parity
      assign byte_odd[gi+1] = ^key_in[8*gi+1 +: 8];
    end
  endgenerate

  assign cd         = {c_reg, d_reg};
  assign parity_bad = ~&byte_odd;
  assign accept     = (state_reg == IDLE) && start;
  assign advance    = (state_reg == RUN) && subkey_ready;
  assign parity_err = perr_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (subkey_ready && cnt_reg == 5'd16) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    busy         = 1'b0;
    subkey_valid = 1'b0;
    done         = 1'b0;
    round_idx    = 5'd0;
    case (state_reg)
      RUN: begin
        busy         = 1'b1;
        subkey_valid = 1'b1;
        round_idx    = dec_reg ? (5'd17 - cnt_reg) : cnt_reg;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // C/D datapath. Encrypt starts at C1/D1 (one left rotation). Decrypt
  // starts at C0/D0, which equals C16/D16, and walks backwards by undoing
  // the shift of the round that was just presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_reg    <= '0;
      d_reg    <= '0;
      cnt_reg  <= 5'd0;
      dec_reg  <= 1'b0;
      perr_reg <= 1'b0;
    end else if (accept) begin
      c_reg    <= decrypt ? pc1_out[1:28]  : rotl(pc1_out[1:28], 2'd1);
      d_reg    <= decrypt ? pc1_out[29:56] : rotl(pc1_out[29:56], 2'd1);
      cnt_reg  <= 5'd1;
      dec_reg  <= decrypt;
      perr_reg <= PARITY_CHECK && parity_bad;
    end else if (advance && cnt_reg != 5'd16) begin
      if (dec_reg) begin
        c_reg <= rotr(c_reg, shift_amt(5'd17 - cnt_reg));
        d_reg <= rotr(d_reg, shift_amt(5'd17 - cnt_reg));
      end else begin
        c_reg <= rotl(c_reg, shift_amt(cnt_reg + 5'd1));
        d_reg <= rotl(d_reg, shift_amt(cnt_reg + 5'd1));
      end
      cnt_reg <= cnt_reg + 5'd1;
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule. Expected subkeys are the
// published DES round keys for key 0x133457799BBCDFF1.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:64] key_in;
  logic        decrypt;
  logic        start;
  logic        busy;
  logic [1:48] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [4:0]  round_idx;
  logic        done;
  logic        parity_err;

  always #5 clk = ~clk;

  des_key_schedule #(.PARITY_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .decrypt(decrypt), .start(start),
    .busy(busy), .subkey(subkey), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .round_idx(round_idx), .done(done),
    .parity_err(parity_err)
  );

  localparam logic [63:0] KEY = 64'h1334_5779_9BBC_DFF1;

  typedef struct {
    logic [63:0] key;
    logic        dec;
    bit          stall;      // pseudo-random backpressure, 5-cycle hold at step 9
    int          start_at;   // step at which a stray start is pulsed (0 = none)
    int          rst_at;     // step at which rst is asserted (0 = none)
    bit          fin_start;  // raise start during FIN
    logic        exp_perr;
  } vec_t;

  logic [47:0] ktab [1:16];
  vec_t        vecs [9];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_sched(input int id, input vec_t v);
    logic [47:0] exp_sk;
    logic [4:0]  exp_idx;
    int          stalls;
    // Accept cycle
    key_in = v.key; decrypt = v.dec; start = 1'b1; subkey_ready = 1'b0;
    tick();
    start = 1'b0; key_in = 64'hFFFF_0000_A5A5_5A5A; decrypt = ~v.dec;
    check($sformatf("v%0d busy@T+1", id), busy, 1);
    check($sformatf("v%0d parity_err@T+1", id), parity_err, v.exp_perr);
    for (int k = 1; k <= 16; k++) begin
      exp_idx = v.dec ? 5'(17 - k) : 5'(k);
      exp_sk  = (v.key == 64'd0) ? 48'd0 : ktab[exp_idx];
      if (k == v.rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check($sformatf("v%0d rst valid", id), subkey_valid, 0);
        check($sformatf("v%0d rst busy", id), busy, 0);
        check($sformatf("v%0d rst subkey", id), subkey, 0);
        check($sformatf("v%0d rst round_idx", id), round_idx, 0);
        check($sformatf("v%0d rst done", id), done, 0);
        tick();
        check($sformatf("v%0d post-rst done", id), done, 0);
        check($sformatf("v%0d post-rst valid", id), subkey_valid, 0);
        $display("v%0d: schedule aborted by rst at step %0d", id, k);
        return;
      end
      stalls = v.stall ? ((k == 9) ? 5 : int'($urandom_range(0, 2))) : 0;
      for (int s = 0; s < stalls; s++) begin
        subkey_ready = 1'b0;
        check($sformatf("v%0d stall k%0d subkey", id, k), subkey, exp_sk);
        check($sformatf("v%0d stall k%0d idx", id, k), round_idx, exp_idx);
        check($sformatf("v%0d stall k%0d valid", id, k), subkey_valid, 1);
        tick();
      end
      subkey_ready = 1'b1;
      if (k == v.start_at) begin
        start = 1'b1; key_in = 64'h0123_4567_89AB_CDEF; decrypt = ~v.dec;
      end
      check($sformatf("v%0d k%0d subkey", id, k), subkey, exp_sk);
      check($sformatf("v%0d k%0d idx", id, k), round_idx, exp_idx);
      check($sformatf("v%0d k%0d valid", id, k), subkey_valid, 1);
      check($sformatf("v%0d k%0d done", id, k), done, 0);
      check($sformatf("v%0d k%0d parity_err", id, k), parity_err, v.exp_perr);
      tick();
      subkey_ready = 1'b0; start = 1'b0;
    end
    // FIN cycle
    check($sformatf("v%0d fin done", id), done, 1);
    check($sformatf("v%0d fin busy", id), busy, 0);
    check($sformatf("v%0d fin valid", id), subkey_valid, 0);
    // Encrypt: 28 rotations bring C/D back to C0/D0, so subkey reads K16.
    exp_sk = (v.key == 64'd0) ? 48'd0 : (v.dec ? ktab[1] : ktab[16]);
    check($sformatf("v%0d fin c/d subkey", id), subkey, exp_sk);
    if (v.fin_start) begin
      start = 1'b1; key_in = v.key; decrypt = 1'b0;
    end
    tick();
    start = 1'b0;
    check($sformatf("v%0d idle done", id), done, 0);
    check($sformatf("v%0d idle busy", id), busy, 0);
    check($sformatf("v%0d idle valid", id), subkey_valid, 0);
    check($sformatf("v%0d idle parity hold", id), parity_err, v.exp_perr);
    $display("v%0d: key=%h dec=%0d schedule complete", id, v.key, v.dec);
  endtask

  initial begin
    ktab[1]  = 48'h1B02EFFC7072; ktab[2]  = 48'h79AED9DBC9E5;
    ktab[3]  = 48'h55FC8A42CF99; ktab[4]  = 48'h72ADD6DB351D;
    ktab[5]  = 48'h7CEC07EB53A8; ktab[6]  = 48'h63A53E507B2F;
    ktab[7]  = 48'hEC84B7F618BC; ktab[8]  = 48'hF78A3AC13BFB;
    ktab[9]  = 48'hE0DBEBEDE781; ktab[10] = 48'hB1F347BA464F;
    ktab[11] = 48'h215FD3DED386; ktab[12] = 48'h7571F59467E9;
    ktab[13] = 48'h97C5D1FABA41; ktab[14] = 48'h5F43B7F2E73A;
    ktab[15] = 48'hBF918D3D3F0A; ktab[16] = 48'hCB3D8B0E17F5;

    //          key     dec   stall start rst fin_start perr
    vecs[0] = '{KEY,   1'b0, 1'b0, 0, 0, 1'b0, 1'b0};  // plain encrypt
    vecs[1] = '{KEY,   1'b1, 1'b0, 0, 0, 1'b0, 1'b0};  // decrypt
    vecs[2] = '{KEY,   1'b0, 1'b1, 0, 0, 1'b0, 1'b0};  // backpressure
    vecs[3] = '{64'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1};  // zero key, parity error
    vecs[4] = '{KEY,   1'b0, 1'b0, 0, 0, 1'b1, 1'b0};  // clears parity, start in FIN
    vecs[5] = '{KEY,   1'b0, 1'b0, 5, 0, 1'b0, 1'b0};  // stray start at round 5
    vecs[6] = '{KEY,   1'b0, 1'b0, 0, 7, 1'b0, 1'b0};  // rst at round 7
    vecs[7] = '{KEY,   1'b0, 1'b0, 0, 0, 1'b0, 1'b0};  // fresh start after rst
    vecs[8] = '{KEY,   1'b1, 1'b1, 0, 0, 1'b0, 1'b0};  // decrypt with backpressure

    rst = 1'b1; start = 1'b0; key_in = '0; decrypt = 1'b0; subkey_ready = 1'b0;
    @(negedge clk);
    tick();
    check("reset busy", busy, 0);
    check("reset valid", subkey_valid, 0);
    check("reset subkey", subkey, 0);
    check("reset round_idx", round_idx, 0);
    check("reset done", done, 0);
    check("reset parity_err", parity_err, 0);
    rst = 1'b0;
    tick();
    check("idle no start valid", subkey_valid, 0);

    for (int i = 0; i < 9; i++) run_sched(i, vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
